// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: shared types, opcode constants and helpers for the RV32 decode stage
package decode_stage_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_CSRRW  = 3'd1;
  localparam logic [2:0] F3_CSRRS  = 3'd2;
  localparam logic [2:0] F3_CSRRC  = 3'd3;
  localparam logic [2:0] F3_CSRRWI = 3'd5;
  localparam logic [2:0] F3_CSRRSI = 3'd6;
  localparam logic [2:0] F3_CSRRCI = 3'd7;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z} imm_sel_e;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;
  typedef struct packed {
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        is_fence;
    logic        is_csr;
    logic [1:0]  csr_op;
    logic        csr_imm;
    logic [11:0] csr_addr;
    logic        is_ecall;
    logic        is_ebreak;
    logic        is_mret;
    logic        is_muldiv;
    logic [2:0]  muldiv_op;
    imm_sel_e    imm_sel;
  } ctrl_signals_t;
  function automatic alu_op_e alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'd0: alu_of = alt ? ALU_SUB : ALU_ADD;
      3'd1: alu_of = ALU_SLL;
      3'd2: alu_of = ALU_SLT;
      3'd3: alu_of = ALU_SLTU;
      3'd4: alu_of = ALU_XOR;
      3'd5: alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6: alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: sign-extended immediate extraction for the I/S/B/U/J formats plus zero-extended CSR zimm
// instr_i: raw instruction, imm_sel_i: format select, imm_o: XLEN-wide immediate
module imm_gen import decode_stage_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_sel_e        imm_sel_i,
  output logic [XLEN-1:0] imm_o
);
  logic s;
  assign s = instr_i[31];
  always_comb
    imm_o = imm_sel_i == IMM_S ? {{(XLEN-11){s}}, instr_i[30:25], instr_i[11:7]} :
            imm_sel_i == IMM_B ? {{(XLEN-12){s}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0} :
            imm_sel_i == IMM_U ? {{(XLEN-31){s}}, instr_i[30:12], 12'b0} :
            imm_sel_i == IMM_J ? {{(XLEN-20){s}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0} :
            imm_sel_i == IMM_Z ? {{(XLEN-5){1'b0}}, instr_i[19:15]} :
                                 {{(XLEN-11){s}}, instr_i[30:20]};
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I(+M, SYSTEM) decode stage with a 2-entry skid buffer and flush
// in_valid/in_ready/in_instr/in_pc: fetch side; out_valid/out_ready: issue side handshake
// out_ctrl/out_imm/out_rs1/out_rs2/out_rd/out_pc/out_illegal: decoded entry from the main register
module decode_stage import decode_stage_pkg::*; #(
  parameter int XLEN      = 32,
  parameter bit EN_M_EXT  = 1'b1,
  parameter bit EN_SYSTEM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_signals_t   out_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  typedef struct packed {
    ctrl_signals_t   ctrl;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;
  logic [6:0] op, f7;
  logic [2:0] f3;
  ctrl_signals_t c;
  logic ill, use_rs1, use_rs2, use_rd, acc, drn;
  imm_sel_e isel;
  logic [XLEN-1:0] imm;
  entry_t dec, main_q, main_d, skid_q, skid_d;
  state_e state_q, state_d;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  always_comb begin
    c = '0;
    ill = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd = 1'b0;
    isel = IMM_I;
    c.funct3 = f3;
    c.csr_addr = in_instr[31:20];
    if (in_instr[1:0] != 2'b11) ill = 1'b1;
    else case (op)
      OP_LUI:    begin use_rd = 1'b1; c.is_lui = 1'b1; c.alu_op = ALU_PASSB; c.alu_src = 1'b1; c.reg_write = 1'b1; isel = IMM_U; end
      OP_AUIPC:  begin use_rd = 1'b1; c.is_auipc = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; isel = IMM_U; end
      OP_JAL:    begin use_rd = 1'b1; c.is_jal = 1'b1; c.reg_write = 1'b1; isel = IMM_J; end
      OP_JALR:   begin use_rd = 1'b1; use_rs1 = 1'b1; c.is_jalr = 1'b1; c.alu_src = 1'b1; c.reg_write = 1'b1; ill = f3 != 3'd0; end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; c.is_branch = 1'b1; c.alu_op = ALU_SUB; isel = IMM_B; ill = f3[2:1] == 2'b01; end
      OP_LOAD:   begin use_rd = 1'b1; use_rs1 = 1'b1; c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; ill = f3 == 3'd3 || f3[2:1] == 2'b11; end
      OP_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; c.mem_write = 1'b1; c.alu_src = 1'b1; isel = IMM_S; ill = f3 > 3'd2; end
      OP_IMM: begin
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        c.reg_write = 1'b1;
        c.alu_src = 1'b1;
        c.alu_op = alu_of(f3, f3 == 3'd5 && f7 == F7_ALT);
        ill = (f3 == 3'd1 && f7 != F7_ZERO) || (f3 == 3'd5 && f7 != F7_ZERO && f7 != F7_ALT);
      end
      OP_OP: begin
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        c.reg_write = 1'b1;
        c.is_muldiv = EN_M_EXT && f7 == F7_MULDIV;
        c.muldiv_op = c.is_muldiv ? f3 : 3'd0;
        c.alu_op = alu_of(f3, f7 == F7_ALT);
        ill = !(c.is_muldiv || f7 == F7_ZERO || (f7 == F7_ALT && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OP_FENCE: c.is_fence = 1'b1;
      OP_SYSTEM: begin
        if (!EN_SYSTEM) ill = 1'b1;
        else case (f3)
          3'd0: begin
            c.is_ecall = in_instr[31:20] == SYS_ECALL;
            c.is_ebreak = in_instr[31:20] == SYS_EBREAK;
            c.is_mret = in_instr[31:20] == SYS_MRET;
            ill = !(c.is_ecall || c.is_ebreak || c.is_mret);
          end
          F3_CSRRW, F3_CSRRS, F3_CSRRC, F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: begin
            use_rd = 1'b1;
            use_rs1 = !f3[2];
            c.is_csr = 1'b1;
            c.csr_op = f3[1:0];
            c.csr_imm = f3[2];
            c.reg_write = 1'b1;
            isel = f3[2] ? IMM_Z : IMM_I;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    c.imm_sel = isel;
    c.reg_write = c.reg_write & !ill & (in_instr[11:7] != 5'd0);
    c.mem_read = c.mem_read & !ill;
    c.mem_write = c.mem_write & !ill;
  end
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i  (in_instr),
    .imm_sel_i(isel),
    .imm_o    (imm)
  );
  assign dec = '{ctrl: c, imm: imm, rs1: use_rs1 ? in_instr[19:15] : 5'd0,
                 rs2: use_rs2 ? in_instr[24:20] : 5'd0, rd: use_rd ? in_instr[11:7] : 5'd0,
                 pc: in_pc, illegal: ill};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state_q <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  // In ONE, an accept without a drain parks the new entry in skid so main keeps FIFO order.
  always_comb begin
    acc = in_valid & in_ready;
    drn = out_valid & out_ready;
    state_d = flush ? ST_EMPTY :
              state_q == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY) :
              state_q == ST_ONE ? (acc & !drn ? ST_FULL : !acc & drn ? ST_EMPTY : ST_ONE) :
              (drn ? ST_ONE : ST_FULL);
    main_d = state_q == ST_FULL ? (drn ? skid_q : main_q) :
             acc & (state_q == ST_EMPTY | drn) ? dec : main_q;
    skid_d = state_q == ST_ONE & acc & !drn ? dec : skid_q;
  end
  always_comb begin
    in_ready = state_q != ST_FULL;
    out_valid = state_q != ST_EMPTY;
    out_ctrl = main_q.ctrl;
    out_imm = main_q.imm;
    out_rs1 = main_q.rs1;
    out_rs2 = main_q.rs2;
    out_rd = main_q.rd;
    out_pc = main_q.pc;
    out_illegal = main_q.illegal;
  end
endmodule
